// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, colours and sizing helper.
// Used by the scan controller and by the game-logic block.
package vga_pkg;
  localparam int CNT_W = 10;

  localparam int VGA_CLK_DIV     = 4;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_ACT_START = 144;
  localparam int VGA_H_ACT_END   = 784;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_ACT_START = 35;
  localparam int VGA_V_ACT_END   = 515;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COLOR_BLACK = 12'h000;
  localparam rgb_t COLOR_WHITE = 12'hFFF;
  localparam rgb_t COLOR_RED   = 12'hF00;
  localparam rgb_t COLOR_GREEN = 12'h0F0;
  localparam rgb_t COLOR_BLUE  = 12'h00F;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_divider.sv
// Counts enable pulses 0..DIV-1 and raises tick combinationally on the last one,
// so tick is coincident with the enable that wraps the count.
module tick_divider
  import vga_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
  end
endmodule

// File: rtl/vga_scan_controller.sv
// VGA raster scan: pixel-rate counters, registered syncs/pixel (one pixel behind
// the counters), and frame/game update pulses, all on clk.
module vga_scan_controller
  import vga_pkg::*;
#(
  parameter int CLK_DIV     = VGA_CLK_DIV,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_ACT_START = VGA_H_ACT_START,
  parameter int H_ACT_END   = VGA_H_ACT_END,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_ACT_START = VGA_V_ACT_START,
  parameter int V_ACT_END   = VGA_V_ACT_END,
  parameter int FRAME_DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  rgb_t             rgb_in,
  output logic [CNT_W-1:0] hCount,
  output logic [CNT_W-1:0] vCount,
  output logic             bright,
  output logic             pixel_tick,
  output logic             hsync,
  output logic             vsync,
  output rgb_t             rgb_out,
  output logic             frame_tick,
  output logic             game_tick
);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SW    = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SW    = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_S = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0] H_ACT_E = CNT_W'(H_ACT_END);
  localparam logic [CNT_W-1:0] V_ACT_S = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0] V_ACT_E = CNT_W'(V_ACT_END);

  logic h_last;
  logic v_last;

  tick_divider #(.DIV(CLK_DIV)) u_pixel_div (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .tick (pixel_tick)
  );

  assign h_last = (hCount == H_LAST);
  assign v_last = (vCount == V_LAST);
  assign bright = (hCount >= H_ACT_S) && (hCount < H_ACT_E) &&
                  (vCount >= V_ACT_S) && (vCount < V_ACT_E);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pixel_tick) begin
      if (h_last) begin
        hCount <= '0;
        vCount <= v_last ? '0 : vCount + CNT_W'(1);
      end else begin
        hCount <= hCount + CNT_W'(1);
      end
    end
  end

  // Outputs describe the pixel the counters just left, keeping all three aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      rgb_out <= '0;
    end else if (pixel_tick) begin
      hsync   <= !(hCount < H_SW);
      vsync   <= !(vCount < V_SW);
      rgb_out <= bright ? rgb_in : '0;
    end
  end

  // Counters start at (0,0), so the first wrap always ends a complete frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_tick <= 1'b0;
    else
      frame_tick <= pixel_tick && h_last && v_last;
  end

  tick_divider #(.DIV(FRAME_DIV)) u_frame_div (
    .clk  (clk),
    .rst  (rst),
    .en   (frame_tick),
    .tick (game_tick)
  );
endmodule

// File: tb/tb_vga_scan_controller.sv
// Directed bench on a shrunken raster: expected scan state is derived from the
// clk count since reset release, independently of the counter structure.
module tb_vga_scan_controller;
  localparam int CLK_DIV     = 4;
  localparam int H_TOTAL     = 20;
  localparam int H_SYNC      = 3;
  localparam int H_ACT_START = 5;
  localparam int H_ACT_END   = 17;
  localparam int V_TOTAL     = 8;
  localparam int V_SYNC      = 2;
  localparam int V_ACT_START = 2;
  localparam int V_ACT_END   = 6;
  localparam int FRAME_DIV   = 3;
  localparam int FRAME_PIX   = H_TOTAL * V_TOTAL;
  localparam int FRAME_CLK   = FRAME_PIX * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] rgb_in;
  logic [9:0]  hCount, vCount;
  logic        bright, pixel_tick, hsync, vsync, frame_tick, game_tick;
  logic [11:0] rgb_out;
  logic        rgb_mode = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Game-logic stand-in: constant white, or the current column as colour.
  assign rgb_in = rgb_mode ? {2'b00, hCount} : 12'hFFF;

  vga_scan_controller #(
    .CLK_DIV(CLK_DIV), .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC),
    .H_ACT_START(H_ACT_START), .H_ACT_END(H_ACT_END),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC),
    .V_ACT_START(V_ACT_START), .V_ACT_END(V_ACT_END),
    .FRAME_DIV(FRAME_DIV)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in),
    .hCount(hCount), .vCount(vCount), .bright(bright),
    .pixel_tick(pixel_tick), .hsync(hsync), .vsync(vsync),
    .rgb_out(rgb_out), .frame_tick(frame_tick), .game_tick(game_tick)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hcount"}, hCount, 0);
    check({tag, "_vcount"}, vCount, 0);
    check({tag, "_pixel_tick"}, pixel_tick, 0);
    check({tag, "_hsync"}, hsync, 1);
    check({tag, "_vsync"}, vsync, 1);
    check({tag, "_rgb_out"}, rgb_out, 0);
    check({tag, "_frame_tick"}, frame_tick, 0);
    check({tag, "_game_tick"}, game_tick, 0);
  endtask

  // State expected t clk edges after reset release.
  task automatic check_scan(input int t, input bit mode);
    int p, h, v, pp, hp, vp;
    logic exp_hs, exp_vs, exp_ft, exp_gt, vis;
    logic [11:0] exp_rgb;
    p = t / CLK_DIV;
    h = p % H_TOTAL;
    v = (p / H_TOTAL) % V_TOTAL;
    check("hcount", hCount, h);
    check("vcount", vCount, v);
    check("pixel_tick", pixel_tick, (t % CLK_DIV) == CLK_DIV - 1);
    check("bright", bright, h >= H_ACT_START && h < H_ACT_END && v >= V_ACT_START && v < V_ACT_END);
    if (p == 0) begin
      exp_hs = 1'b1;
      exp_vs = 1'b1;
      exp_rgb = 12'h000;
    end else begin
      pp = p - 1;
      hp = pp % H_TOTAL;
      vp = (pp / H_TOTAL) % V_TOTAL;
      vis = hp >= H_ACT_START && hp < H_ACT_END && vp >= V_ACT_START && vp < V_ACT_END;
      exp_hs = hp >= H_SYNC;
      exp_vs = vp >= V_SYNC;
      exp_rgb = vis ? (mode ? 12'(hp) : 12'hFFF) : 12'h000;
    end
    check("hsync", hsync, exp_hs);
    check("vsync", vsync, exp_vs);
    check("rgb_out", rgb_out, exp_rgb);
    exp_ft = (t % CLK_DIV == 0) && (p > 0) && (p % FRAME_PIX == 0);
    exp_gt = exp_ft && ((p / FRAME_PIX) % FRAME_DIV == 0);
    check("frame_tick", frame_tick, exp_ft);
    check("game_tick", game_tick, exp_gt);
  endtask

  // Call right after releasing rst; runs a fixed number of clk cycles.
  task automatic run_scan(input int cycles, input bit mode,
                          output int n_ft, output int n_gt, output int first_pt);
    int last_ft;
    last_ft = -1;
    n_ft = 0;
    n_gt = 0;
    first_pt = -1;
    #1;
    check_scan(0, mode);
    for (int t = 1; t <= cycles; t++) begin
      @(posedge clk);
      #1;
      check_scan(t, mode);
      if (pixel_tick && first_pt < 0) first_pt = t;
      if (frame_tick) begin
        n_ft++;
        if (last_ft >= 0) check("frame_spacing", t - last_ft, FRAME_CLK);
        last_ft = t;
      end
      if (game_tick) n_gt++;
    end
  endtask

  initial begin
    int n_ft, n_gt, first_pt;

    repeat (3) @(negedge clk);
    check_reset_state("por");

    // Three full frames of white: blanking, sync widths, frame/game pulses.
    rgb_mode = 1'b0;
    rst = 1'b0;
    run_scan(3 * FRAME_CLK + 8, 1'b0, n_ft, n_gt, first_pt);
    check("first_pixel_clk", first_pt + 1, CLK_DIV);
    check("frame_tick_count", n_ft, 3);
    check("game_tick_count", n_gt, 1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("rst2");

    // Column-as-colour run, stopped mid-frame by an asynchronous reset.
    rgb_mode = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_scan(4 * H_TOTAL * CLK_DIV + 30, 1'b1, n_ft, n_gt, first_pt);
    check("mid_rgb_nonzero", rgb_out != 12'h000, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async");
    repeat (3) begin
      @(negedge clk);
      check_reset_state("hold");
    end

    // Restart from (0,0): first frame_tick only after a full frame, no game_tick.
    rst = 1'b0;
    run_scan(FRAME_CLK + 20, 1'b1, n_ft, n_gt, first_pt);
    check("restart_frame_ticks", n_ft, 1);
    check("restart_game_ticks", n_gt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
